// File: rtl/imem_loader.sv
// Serial program loader: turns a UART byte stream (LE length, then LE words)
// into one instruction-memory write per word at auto-incrementing addresses.
module imem_loader #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [31:0]       wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_LAST,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q;
    logic [31:0]       len_q;
    logic [23:0]       asm_q;
    logic [1:0]        byte_idx_q;
    logic [TO_W-1:0]   to_cnt_q;

    // The 4th byte of a word/length goes straight into the result, so only
    // the first three bytes need storage.
    logic [31:0]       word_d;
    logic [ADDR_W:0]   count_d;
    logic              to_expire;
    logic              last_word;
    logic              oversize;

    assign word_d    = {rx_data_i, asm_q};
    assign count_d   = word_count_o + 1'b1;
    assign to_expire = (to_cnt_q == TO_W'(TIMEOUT - 2));
    assign last_word = (32'(count_d) == len_q);
    assign oversize  = ({1'b0, word_d} > (33'd1 << ADDR_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            asm_q        <= '0;
            byte_idx_q   <= '0;
            to_cnt_q     <= '0;
            we_o         <= 1'b0;
            waddr_o      <= '0;
            wdata_o      <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            word_count_o <= '0;
        end else begin
            we_o   <= 1'b0;
            done_o <= 1'b0;
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (start_i) begin
                        state_q      <= S_LEN;
                        busy_o       <= 1'b1;
                        error_o      <= 1'b0;
                        word_count_o <= '0;
                        byte_idx_q   <= '0;
                        to_cnt_q     <= '0;
                    end
                end
                S_LEN, S_DATA: begin
                    if (rx_valid_i) begin
                        to_cnt_q   <= '0;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0:    asm_q[7:0]   <= rx_data_i;
                            2'd1:    asm_q[15:8]  <= rx_data_i;
                            2'd2:    asm_q[23:16] <= rx_data_i;
                            default: ;
                        endcase
                        if (byte_idx_q == 2'd3) begin
                            if (state_q == S_LEN) begin
                                len_q <= word_d;
                                if (oversize) begin
                                    state_q <= S_ERR;
                                    error_o <= 1'b1;
                                    busy_o  <= 1'b0;
                                end else if (word_d == 32'd0) begin
                                    state_q <= S_DONE;
                                    done_o  <= 1'b1;
                                    busy_o  <= 1'b0;
                                end else begin
                                    state_q <= S_DATA;
                                end
                            end else begin
                                we_o         <= 1'b1;
                                waddr_o      <= word_count_o[ADDR_W-1:0];
                                wdata_o      <= word_d;
                                word_count_o <= count_d;
                                if (last_word) begin
                                    state_q <= S_LAST;
                                end
                            end
                        end
                    end else if (to_expire) begin
                        // Partial word is dropped; a new start resets the index anyway.
                        state_q    <= S_ERR;
                        error_o    <= 1'b1;
                        busy_o     <= 1'b0;
                        byte_idx_q <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                S_LAST: begin
                    state_q <= S_DONE;
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte-count based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_imem_loader;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .we_o         (we),
        .waddr_o      (waddr),
        .wdata_o      (wdata),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .word_count_o (word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a load is a running count of accepted bytes.
    bit                m_active;
    bit                m_pend;
    int                m_bytes;
    int                m_gap;
    logic [7:0]        bb [4];
    logic [31:0]       m_n;
    logic              exp_we    = 1'b0;
    logic [ADDR_W-1:0] exp_waddr = '0;
    logic [31:0]       exp_wdata = '0;
    logic              exp_busy  = 1'b0;
    logic              exp_done  = 1'b0;
    logic              exp_error = 1'b0;
    logic [ADDR_W:0]   exp_wc    = '0;

    task automatic model_step();
        bit prev_done;
        int widx;
        if (rst) begin
            m_active = 0; m_pend = 0; m_bytes = 0; m_gap = 0; m_n = '0;
            exp_we = 0; exp_waddr = '0; exp_wdata = '0; exp_busy = 0;
            exp_done = 0; exp_error = 0; exp_wc = '0;
        end else begin
            prev_done = exp_done;
            exp_we    = 0;
            exp_done  = 0;
            if (m_pend) begin
                m_pend = 0; m_active = 0; exp_done = 1; exp_busy = 0;
            end else if (!m_active) begin
                if (start && !prev_done) begin
                    m_active = 1; exp_busy = 1; exp_error = 0; exp_wc = '0;
                    m_bytes = 0; m_gap = 0;
                end
            end else if (rx_valid) begin
                m_gap = 0;
                bb[m_bytes % 4] = rx_data;
                m_bytes++;
                if (m_bytes == 4) begin
                    m_n = {bb[3], bb[2], bb[1], bb[0]};
                    if (longint'(m_n) > (longint'(1) << ADDR_W)) begin
                        m_active = 0; exp_error = 1; exp_busy = 0;
                    end else if (m_n == 0) begin
                        m_active = 0; exp_done = 1; exp_busy = 0;
                    end
                end else if (m_bytes > 4 && (m_bytes % 4) == 0) begin
                    widx      = (m_bytes - 4) / 4;
                    exp_we    = 1;
                    exp_waddr = ADDR_W'(widx - 1);
                    exp_wdata = {bb[3], bb[2], bb[1], bb[0]};
                    exp_wc    = (ADDR_W + 1)'(widx);
                    if (widx == int'(m_n)) m_pend = 1;
                end
            end else begin
                m_gap++;
                if (m_gap == TIMEOUT - 1) begin
                    m_active = 0; exp_error = 1; exp_busy = 0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        checks++;
        if ({we, waddr, wdata, busy, done, error, word_count} !==
            {exp_we, exp_waddr, exp_wdata, exp_busy, exp_done, exp_error, exp_wc}) begin
            failures++;
            $display("FAIL cycle%0d got we=%0b waddr=%0h wdata=%08h busy=%0b done=%0b error=%0b wc=%0d need we=%0b waddr=%0h wdata=%08h busy=%0b done=%0b error=%0b wc=%0d",
                     cyc, we, waddr, wdata, busy, done, error, word_count,
                     exp_we, exp_waddr, exp_wdata, exp_busy, exp_done, exp_error, exp_wc);
        end
    end

    // Observed write log and done timing for the literal checks.
    logic [ADDR_W+31:0] wlog [$];
    int n_done      = 0;
    int last_we_cyc = 0;
    int done_cyc    = 0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (we) begin
                wlog.push_back({waddr, wdata});
                last_we_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h need=%0h", name, got, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_log();
        wlog.delete();
        n_done = 0;
    endtask

    function automatic logic [ADDR_W+31:0] entry(input int a, input logic [31:0] d);
        return {ADDR_W'(a), d};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark;
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_error", error, 0);
        chk("reset_wc", word_count, 0);

        // Bytes without start are ignored
        clear_log();
        send(8'h13); send(8'h05); send(8'hA0);
        send_word(32'h0000_0001);
        idle(2);
        $display("txn idle_bytes writes=%0d", wlog.size());
        chk("idle_nwr", wlog.size(), 0);
        chk("idle_busy", busy, 0);

        // Normal two-word load
        clear_log();
        pulse_start();
        send_word(32'd2);
        send_word(32'h00A0_0513);
        send_word(32'h0010_0073);
        idle(3);
        $display("txn normal writes=%0d wc=%0d", wlog.size(), word_count);
        chk("norm_nwr", wlog.size(), 2);
        chk("norm_w0", wlog[0], entry(0, 32'h00A0_0513));
        chk("norm_w1", wlog[1], entry(1, 32'h0010_0073));
        chk("norm_ndone", n_done, 1);
        chk("norm_done_lat", done_cyc - last_we_cyc, 1);
        chk("norm_wc", word_count, 2);
        chk("norm_busy", busy, 0);

        // Zero length
        clear_log();
        pulse_start();
        send_word(32'd0);
        mark = cyc;
        idle(3);
        $display("txn zero_len writes=%0d done=%0d", wlog.size(), n_done);
        chk("zero_nwr", wlog.size(), 0);
        chk("zero_ndone", n_done, 1);
        chk("zero_done_cyc", done_cyc, mark);
        chk("zero_wc", word_count, 0);

        // Oversize length 17 with 16-word memory
        clear_log();
        pulse_start();
        send_word(32'd17);
        idle(2);
        $display("txn oversize error=%0b busy=%0b", error, busy);
        chk("over_error", error, 1);
        chk("over_busy", busy, 0);
        chk("over_nwr", wlog.size(), 0);
        pulse_start();
        chk("over_clear", error, 0);

        // Exactly full memory: 16 words
        send_word(32'd16);
        for (int i = 0; i < 16; i++) send_word(32'hC0DE_0000 + 32'(i));
        idle(3);
        $display("txn full writes=%0d wc=%0d", wlog.size(), word_count);
        chk("full_nwr", wlog.size(), 16);
        chk("full_last", wlog[15], entry(15, 32'hC0DE_000F));
        chk("full_wc", word_count, 16);
        chk("full_error", error, 0);

        // Timeout after two data bytes
        clear_log();
        pulse_start();
        send_word(32'd1);
        send(8'hAA); send(8'hBB);
        idle(14);
        chk("to_pre_error", error, 0);
        chk("to_pre_busy", busy, 1);
        idle(1);
        $display("txn timeout error=%0b busy=%0b", error, busy);
        chk("to_error", error, 1);
        chk("to_busy", busy, 0);
        chk("to_nwr", wlog.size(), 0);

        // Byte on the expiry cycle rescues the load
        clear_log();
        pulse_start();
        send_word(32'd1);
        send(8'hAA); send(8'hBB);
        idle(14);
        send(8'hCC); send(8'hDD);
        idle(3);
        $display("txn timeout_edge writes=%0d error=%0b", wlog.size(), error);
        chk("edge_error", error, 0);
        chk("edge_nwr", wlog.size(), 1);
        chk("edge_w0", wlog[0], entry(0, 32'hDDCC_BBAA));
        chk("edge_ndone", n_done, 1);

        // start during DATA is ignored
        clear_log();
        pulse_start();
        send_word(32'd2);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        pulse_start();
        send(8'h66); send(8'h77); send(8'h88);
        send_word(32'hCCBB_AA99);
        idle(3);
        $display("txn start_in_data writes=%0d wc=%0d", wlog.size(), word_count);
        chk("sid_nwr", wlog.size(), 2);
        chk("sid_w0", wlog[0], entry(0, 32'h4433_2211));
        chk("sid_w1", wlog[1], entry(1, 32'h8877_6655));
        chk("sid_wc", word_count, 2);

        // start with rx_valid in the same cycle: byte dropped
        clear_log();
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'h05;
        @(negedge clk);
        start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        send_word(32'd1);
        send_word(32'h0403_0201);
        idle(3);
        $display("txn start_rx writes=%0d error=%0b", wlog.size(), error);
        chk("srx_error", error, 0);
        chk("srx_nwr", wlog.size(), 1);
        chk("srx_w0", wlog[0], entry(0, 32'h0403_0201));

        // Reset mid-load
        clear_log();
        pulse_start();
        send_word(32'd3);
        for (int i = 1; i <= 6; i++) send(8'(i));
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_outs", {we, waddr, wdata, busy, done, error, word_count}, 0);
        #2 rst = 1'b0;
        idle(3);
        $display("txn reset_mid writes=%0d busy=%0b wc=%0d", wlog.size(), busy, word_count);
        chk("rst_nwr", wlog.size(), 1);
        chk("rst_w0", wlog[0], entry(0, 32'h0403_0201));
        chk("rst_busy", busy, 0);
        chk("rst_wc", word_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
